// File: rtl/spi_weight_rx.sv
// SPI slave that deserialises 32-bit weight frames in the CLOCK domain and
// loads 20-bit halves of the four beamformer weight buses.
`timescale 1ns/1ps
module spi_weight_rx #(
    parameter int FRAME_BITS  = 32,
    parameter int ADDR_BITS   = 7,
    parameter int HALF_BITS   = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLOCK,
    input  logic                   RESETB,
    input  logic                   SCLK,
    input  logic                   MOSI,
    input  logic                   SS,
    output logic [2*HALF_BITS-1:0] W_COS_1,
    output logic [2*HALF_BITS-1:0] W_SIN_1,
    output logic [2*HALF_BITS-1:0] W_COS_2,
    output logic [2*HALF_BITS-1:0] W_SIN_2,
    output logic                   WR_STROBE,
    output logic                   FRAME_ERR,
    output logic                   CFG_DONE
);

    localparam int CNT_BITS = $clog2(FRAME_BITS + 1);
    localparam int WW       = 2 * HALF_BITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, WAIT_SS} state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, ss_sync;
    logic                    sclk_hist, ss_hist;
    logic                    sclk_rise, ss_fall, ss_rise, ss_high, mosi_bit;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [CNT_BITS-1:0]     bit_count;
    logic                    last_bit;
    logic [ADDR_BITS-1:0]    frame_addr;
    logic [HALF_BITS-1:0]    payload;
    logic [2:0]              slot;
    logic                    addr_ok, write_en, err_en;
    logic [7:0]              written_mask;
    logic                    unused_reserved;

    always_ff @(posedge CLOCK or negedge RESETB) begin
        if (!RESETB) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_hist <= 1'b0;
            ss_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ss_hist   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
    assign ss_fall   = ~ss_sync[SYNC_STAGES-1] & ss_hist;
    assign ss_rise   = ss_sync[SYNC_STAGES-1] & ~ss_hist;
    assign ss_high   = ss_sync[SYNC_STAGES-1];
    assign mosi_bit  = mosi_sync[SYNC_STAGES-1];
    assign last_bit  = sclk_rise && (bit_count == CNT_BITS'(FRAME_BITS - 1));

    always_ff @(posedge CLOCK or negedge RESETB) begin
        if (!RESETB) state <= IDLE;
        else         state <= state_next;
    end

    // WAIT_SS leaves on the SS level so a rise that coincided with the last
    // SCLK edge (already consumed by SHIFT) does not strand the FSM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DECODE;
                     else if (ss_rise) state_next = IDLE;
            DECODE:  state_next = WAIT_SS;
            WAIT_SS: if (ss_high) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETB) begin
        if (!RESETB) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (state == IDLE && ss_fall) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (state == SHIFT && sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_bit};
            bit_count <= bit_count + CNT_BITS'(1);
        end
    end

    assign frame_addr      = shift_reg[FRAME_BITS-2 -: ADDR_BITS];
    assign payload         = shift_reg[HALF_BITS-1:0];
    assign slot            = 3'(frame_addr - ADDR_BITS'(1));
    assign unused_reserved = ^shift_reg[FRAME_BITS-ADDR_BITS-2:HALF_BITS];

    always_comb begin
        addr_ok  = 1'b0;
        write_en = 1'b0;
        err_en   = 1'b0;
        addr_ok  = (frame_addr != '0) && (frame_addr <= ADDR_BITS'(8));
        if (state == DECODE && shift_reg[FRAME_BITS-1]) begin
            write_en = addr_ok;
            err_en   = !addr_ok;
        end
        if (state == SHIFT && ss_rise && !last_bit) err_en = 1'b1;
    end

    // Weight buses only change here, one cycle after DECODE, as whole halves.
    always_ff @(posedge CLOCK or negedge RESETB) begin
        if (!RESETB) begin
            W_COS_1      <= '0;
            W_SIN_1      <= '0;
            W_COS_2      <= '0;
            W_SIN_2      <= '0;
            WR_STROBE    <= 1'b0;
            FRAME_ERR    <= 1'b0;
            written_mask <= '0;
        end else begin
            WR_STROBE <= write_en;
            FRAME_ERR <= err_en;
            if (write_en) begin
                written_mask[slot] <= 1'b1;
                case (slot)
                    3'd0: W_COS_1[HALF_BITS-1:0] <= payload;
                    3'd1: W_COS_1[WW-1:HALF_BITS] <= payload;
                    3'd2: W_SIN_1[HALF_BITS-1:0] <= payload;
                    3'd3: W_SIN_1[WW-1:HALF_BITS] <= payload;
                    3'd4: W_COS_2[HALF_BITS-1:0] <= payload;
                    3'd5: W_COS_2[WW-1:HALF_BITS] <= payload;
                    3'd6: W_SIN_2[HALF_BITS-1:0] <= payload;
                    default: W_SIN_2[WW-1:HALF_BITS] <= payload;
                endcase
            end
        end
    end

    assign CFG_DONE = &written_mask;

endmodule
